bat_mem_responder: RTL and testbench
====================================

// Module: bat_mem_responder
// PURPOSE
//  Memory-side responder to the BatAmateur microcode controller's MAR/RAM strobes.
//  Holds MAR and RAM array; drives read data onto CPU bus; accepts writes from bus.
//  Owns boot sequence: zero-fill RAM, then accept program image via a valid/ready
//  load port while holding CPU in reset (CPU_HOLD); releases CPU when image complete.
// PARAMETERS
//  ADDR_W  8   MAR / RAM address width; RAM depth = 2**ADDR_W words
//  DATA_W  16  bus and RAM word width (instruction width); must be >= ADDR_W
// PORTS
//  CLK       in   1       system clock, all state updates on rising edge
//  RST       in   1       asynchronous, active-high reset
//  MAR_LOAD  in   1       controller: load MAR this cycle
//  MAR_EN    in   1       controller: 1 = normal; 0 = controller fault (default uOP)
//  RAM_RW    in   1       controller: 1 = read, 0 = write
//  RAM_EN    in   1       controller: RAM access this cycle
//  BUS_IN    in   DATA_W  CPU bus value (from PC/IR/regs)
//  BUS_OUT   out  DATA_W  RAM read data onto CPU bus
//  BUS_DRV   out  1       1 = BUS_OUT valid, responder owns bus
//  MAR_Q     out  ADDR_W  current MAR value (debug/observation)
//  LD_VALID  in   1       loader: beat valid
//  LD_READY  out  1       loader: responder accepts beat
//  LD_ADDR   in   ADDR_W  loader: word address
//  LD_DATA   in   DATA_W  loader: word data
//  LD_LAST   in   1       loader: final beat of image
//  CPU_HOLD  out  1       1 = keep CPU/controller in reset
//  ERR       out  1       sticky protocol-error flag
// BEHAVIOUR
//  Reset (async): state=CLEAR, clr_cnt=0, MAR=0, ERR=0; outputs BUS_OUT=0,
//   BUS_DRV=0, LD_READY=0, CPU_HOLD=1. RAM contents undefined until CLEAR ends.
//  FSM (registered): CLEAR -> LOAD -> RUN; RUN is terminal until RST.
//  CLEAR: one write/cycle mem[clr_cnt]<=0, clr_cnt++; after writing addr 2**ADDR_W-1
//   -> LOAD (exactly 2**ADDR_W cycles). LD_READY=0; controller strobes ignored.
//  LOAD: LD_READY=1. Beat accepted on edge with LD_VALID&LD_READY: mem[LD_ADDR]
//   <=LD_DATA. Accepted beat with LD_LAST=1 -> RUN next cycle. LD_LAST without
//   LD_VALID ignored. Controller strobes ignored; BUS_DRV=0.
//  CPU_HOLD = (state != RUN), registered-state decode, no glitch.
//  RUN: LD_READY=0, LD_* ignored.
//   Read: RAM_EN&RAM_RW -> BUS_OUT=mem[MAR], BUS_DRV=1, combinational, same cycle
//    (zero latency; controller samples within the strobe cycle). Otherwise BUS_OUT=0,
//    BUS_DRV=0.
//   Write: RAM_EN&~RAM_RW&MAR_EN -> mem[MAR]<=BUS_IN at edge; BUS_DRV=0.
//   MAR load: MAR_LOAD&MAR_EN at edge: if RAM read active same cycle (indirect
//    addressing) MAR<=mem[MAR][ADDR_W-1:0] (old MAR addresses read); else
//    MAR<=BUS_IN[ADDR_W-1:0]. Upper data bits discarded; no wrap logic needed.
//   MAR_EN=0: MAR and RAM frozen (no write, no MAR load); ERR<=1.
//   RAM write with MAR_LOAD same cycle: write uses old MAR, MAR loads BUS_IN, ERR<=1.
//   ERR sticky until RST; never set outside RUN.
//  Reset mid-CLEAR/LOAD/RUN: immediate return to reset values; restart CLEAR.
// TESTING
//  T1 RST pulse, ADDR_W=8 -> LD_READY rises exactly 256 cycles after RST falls;
//   LD_VALID held high during CLEAR accepts nothing; CPU_HOLD=1 throughout.
//  T2 LOAD 0x1234@0x00, 0x7F00@0x01, 0xBEEF@0x10 (LD_LAST on 3rd, one idle gap) ->
//   CPU_HOLD=0 the cycle after 3rd beat; LD_READY=0 thereafter.
//  T3 RUN: MAR_LOAD, BUS_IN=0xAB10 -> MAR_Q=0x10; then RAM_EN,RAM_RW=1 ->
//   BUS_OUT=0xBEEF, BUS_DRV=1 same cycle; unloaded addr 0x55 reads 0x0000.
//  T4 Indirect: mem[0x20]=0x0010, MAR=0x20, MAR_LOAD+RAM_EN read -> BUS_OUT=0x0010,
//   next cycle MAR_Q=0x10.
//  T5 Write: MAR=0x30, RAM_EN,RAM_RW=0,BUS_IN=0x5555 -> BUS_DRV=0; readback 0x5555;
//   MAR_EN=0 during write to 0x31 -> mem[0x31] unchanged, ERR=1 stays 1.
//  T6 RST asserted mid-LOAD after 1 beat -> MAR_Q=0, CPU_HOLD=1, ERR=0, CLEAR
//   re-runs 256 cycles, prior beat zeroed.

Source files
------------

// File: rtl/bat_mem_responder_if.sv
// Bus bundle between the BatAmateur controller/loader side and the memory
// responder.
//   Controller strobes : MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, BUS_IN
//   Responder to bus   : BUS_OUT, BUS_DRV, MAR_Q
//   Image loader       : LD_VALID, LD_ADDR, LD_DATA, LD_LAST in; LD_READY out
//   Status             : CPU_HOLD, ERR
// The slave modport is the responder's view. The master modport is the
// controller/loader view.
interface bat_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic              MAR_LOAD;
  logic              MAR_EN;
  logic              RAM_RW;
  logic              RAM_EN;
  logic [DATA_W-1:0] BUS_IN;
  logic [DATA_W-1:0] BUS_OUT;
  logic              BUS_DRV;
  logic [ADDR_W-1:0] MAR_Q;
  logic              LD_VALID;
  logic              LD_READY;
  logic [ADDR_W-1:0] LD_ADDR;
  logic [DATA_W-1:0] LD_DATA;
  logic              LD_LAST;
  logic              CPU_HOLD;
  logic              ERR;

  modport slave (
    input  MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, BUS_IN,
    input  LD_VALID, LD_ADDR, LD_DATA, LD_LAST,
    output BUS_OUT, BUS_DRV, MAR_Q, LD_READY, CPU_HOLD, ERR
  );

  modport master (
    output MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, BUS_IN,
    output LD_VALID, LD_ADDR, LD_DATA, LD_LAST,
    input  BUS_OUT, BUS_DRV, MAR_Q, LD_READY, CPU_HOLD, ERR
  );
endinterface

// File: rtl/bat_mem_responder.sv
// Memory-side responder for the BatAmateur microcode controller.
// It holds the MAR and the RAM array. It returns read data onto the CPU bus
// and accepts writes from the bus. It also runs the boot sequence: it
// zero-fills RAM, then takes a program image from the load port while the
// CPU is held in reset.
// Ports:
//   CLK  system clock, all state updates on the rising edge
//   RST  asynchronous active-high reset
//   bus  bat_mem_responder_if.slave (controller strobes, bus data, loader
//        port, CPU_HOLD, ERR)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | zero-fill RAM one word per cycle; loader and controller ignored
// ST_LOAD  | LD_READY=1, accept image beats until a beat with LD_LAST is taken
// ST_RUN   | CPU released; serve MAR/RAM strobes; terminal until RST
module bat_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic CLK,
  input  logic RST,
  bat_mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              rd_req;
  logic              wr_req;
  logic [DATA_W-1:0] rd_word;

  assign rd_req  = bus.RAM_EN & bus.RAM_RW;
  assign wr_req  = bus.RAM_EN & ~bus.RAM_RW;
  assign rd_word = mem[mar_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      mar_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      mar_q     <= mar_d;
      err_q     <= err_d;
    end
  end

  // The RAM has a single write port. CLEAR, LOAD and RUN writes are
  // mutually exclusive by state.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mar_d     = mar_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (bus.LD_VALID) begin
          mem_we    = 1'b1;
          mem_waddr = bus.LD_ADDR;
          mem_wdata = bus.LD_DATA;
          if (bus.LD_LAST) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (!bus.MAR_EN) begin
          // Controller fault: freeze MAR and RAM, and flag it.
          err_d = 1'b1;
        end else begin
          if (wr_req) begin
            mem_we    = 1'b1;
            mem_waddr = mar_q;
            mem_wdata = bus.BUS_IN;
          end
          if (bus.MAR_LOAD) begin
            // A read in the same cycle is indirect addressing. The word
            // addressed by the old MAR becomes the new MAR.
            if (rd_req) begin
              mar_d = rd_word[ADDR_W-1:0];
            end else begin
              mar_d = bus.BUS_IN[ADDR_W-1:0];
            end
            // A write with MAR_LOAD still lands at the old MAR, but it is a
            // protocol violation.
            if (wr_req) begin
              err_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Read data is zero-latency so the controller can sample it within the
  // strobe cycle.
  always_comb begin
    bus.BUS_OUT = '0;
    bus.BUS_DRV = 1'b0;
    if (state_q == ST_RUN && rd_req) begin
      bus.BUS_OUT = rd_word;
      bus.BUS_DRV = 1'b1;
    end
  end

  assign bus.MAR_Q    = mar_q;
  assign bus.LD_READY = (state_q == ST_LOAD);
  assign bus.CPU_HOLD = (state_q != ST_RUN);
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_bat_mem_responder.sv
module tb_bat_mem_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  bat_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bat_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  logic [DATA_W-1:0] exp_q [$];
  string             tag_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every cycle in which the responder drives the bus
  // consumes one expected read word.
  always @(negedge CLK) begin
    if (!RST && bus.BUS_DRV === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bus_drv", 32'(bus.BUS_OUT), 32'hFFFF_FFFF);
      end else begin
        automatic logic [DATA_W-1:0] e = exp_q.pop_front();
        automatic string t = tag_q.pop_front();
        check(t, 32'(bus.BUS_OUT), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts cycles from RST release until LD_READY is seen. Returns -1 if it
  // never appears. Also reports whether CPU_HOLD dropped during the wait.
  task automatic release_and_wait(output int n, output bit hold_bad);
    n = -1;
    hold_bad = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.CPU_HOLD !== 1'b1) hold_bad = 1'b1;
      if (bus.LD_READY === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic beat(input logic [7:0] a, input logic [15:0] d, input logic last);
    bus.LD_VALID = 1'b1; bus.LD_ADDR = a; bus.LD_DATA = d; bus.LD_LAST = last;
    tick();
    bus.LD_VALID = 1'b0; bus.LD_LAST = 1'b0;
  endtask

  task automatic set_mar(input logic [15:0] v);
    bus.MAR_LOAD = 1'b1; bus.BUS_IN = v;
    tick();
    bus.MAR_LOAD = 1'b0;
  endtask

  task automatic read_exp(input string t, input logic [15:0] e);
    bus.RAM_EN = 1'b1; bus.RAM_RW = 1'b1;
    exp_q.push_back(e); tag_q.push_back(t);
    tick();
    bus.RAM_EN = 1'b0;
  endtask

  task automatic write_word(input string t, input logic [15:0] d);
    bus.RAM_EN = 1'b1; bus.RAM_RW = 1'b0; bus.BUS_IN = d;
    @(negedge CLK);
    check(t, 32'(bus.BUS_DRV), 32'd0);
    tick();
    bus.RAM_EN = 1'b0; bus.RAM_RW = 1'b1;
  endtask

  int n;
  bit hold_bad;

  initial begin
    bus.MAR_LOAD = 1'b0; bus.MAR_EN = 1'b1; bus.RAM_RW = 1'b1; bus.RAM_EN = 1'b0;
    bus.BUS_IN = '0; bus.LD_VALID = 1'b0; bus.LD_ADDR = '0; bus.LD_DATA = '0;
    bus.LD_LAST = 1'b0;

    #23;
    check("rst_cpu_hold", 32'(bus.CPU_HOLD), 32'd1);
    check("rst_ld_ready", 32'(bus.LD_READY), 32'd0);
    check("rst_bus_drv",  32'(bus.BUS_DRV),  32'd0);
    check("rst_bus_out",  32'(bus.BUS_OUT),  32'd0);
    check("rst_mar",      32'(bus.MAR_Q),    32'd0);
    check("rst_err",      32'(bus.ERR),      32'd0);

    // T1: an LD_LAST beat offered throughout CLEAR must not be taken.
    bus.LD_VALID = 1'b1; bus.LD_ADDR = 8'h05; bus.LD_DATA = 16'hDEAD; bus.LD_LAST = 1'b1;
    release_and_wait(n, hold_bad);
    bus.LD_VALID = 1'b0; bus.LD_LAST = 1'b0;
    check("t1_ready_latency", 32'(n), 32'd256);
    check("t1_hold_during_clear", 32'(hold_bad), 32'd0);

    // T2: program image, with an idle gap before the last beat.
    beat(8'h00, 16'h1234, 1'b0);
    beat(8'h01, 16'h7F00, 1'b0);
    tick();
    check("t2_ready_in_gap", 32'(bus.LD_READY), 32'd1);
    bus.LD_VALID = 1'b1; bus.LD_ADDR = 8'h10; bus.LD_DATA = 16'hBEEF; bus.LD_LAST = 1'b1;
    @(negedge CLK);
    check("t2_hold_before_last", 32'(bus.CPU_HOLD), 32'd1);
    tick();
    check("t2_hold_released", 32'(bus.CPU_HOLD), 32'd0);
    check("t2_ready_dropped",  32'(bus.LD_READY), 32'd0);
    // Loader traffic in RUN is ignored.
    bus.LD_LAST = 1'b0; bus.LD_ADDR = 8'h55; bus.LD_DATA = 16'h9999;
    tick();
    bus.LD_VALID = 1'b0;
    check("t2_ready_stays_low", 32'(bus.LD_READY), 32'd0);

    // T3: direct MAR load and reads. The upper BUS_IN bits are discarded.
    set_mar(16'hAB10);
    check("t3_mar_q", 32'(bus.MAR_Q), 32'h10);
    read_exp("t3_read_10", 16'hBEEF);
    set_mar(16'h0000);
    read_exp("t3_read_00", 16'h1234);
    set_mar(16'h0001);
    read_exp("t3_read_01", 16'h7F00);
    set_mar(16'h0055);
    read_exp("t3_read_55_unloaded", 16'h0000);

    // T4: indirect addressing.
    set_mar(16'h0020);
    write_word("t4_write_no_drv", 16'h0010);
    set_mar(16'h0020);
    bus.MAR_LOAD = 1'b1; bus.RAM_EN = 1'b1; bus.RAM_RW = 1'b1;
    exp_q.push_back(16'h0010); tag_q.push_back("t4_indirect_read");
    tick();
    bus.MAR_LOAD = 1'b0; bus.RAM_EN = 1'b0;
    check("t4_mar_indirect", 32'(bus.MAR_Q), 32'h10);
    read_exp("t4_read_after_indirect", 16'hBEEF);
    check("t4_err_clean", 32'(bus.ERR), 32'd0);

    // T5: write, readback, then a write attempted with MAR_EN low.
    set_mar(16'h0030);
    write_word("t5_write_no_drv", 16'h5555);
    read_exp("t5_readback_30", 16'h5555);
    set_mar(16'h0031);
    bus.MAR_EN = 1'b0; bus.RAM_EN = 1'b1; bus.RAM_RW = 1'b0; bus.BUS_IN = 16'h7777;
    tick();
    bus.MAR_LOAD = 1'b1; bus.RAM_EN = 1'b0; bus.RAM_RW = 1'b1; bus.BUS_IN = 16'h0044;
    tick();
    bus.MAR_LOAD = 1'b0; bus.MAR_EN = 1'b1;
    check("t5_err_set", 32'(bus.ERR), 32'd1);
    check("t5_mar_frozen", 32'(bus.MAR_Q), 32'h31);
    read_exp("t5_read_31_unchanged", 16'h0000);
    repeat (3) tick();
    check("t5_err_sticky", 32'(bus.ERR), 32'd1);

    // T6: reset while in LOAD after one beat.
    #2 RST = 1'b1;
    #2;
    release_and_wait(n, hold_bad);
    check("t6_first_clear_latency", 32'(n), 32'd256);
    beat(8'h40, 16'hCAFE, 1'b0);
    #1 RST = 1'b1;
    #2;
    check("t6_mar_reset",  32'(bus.MAR_Q),    32'd0);
    check("t6_hold_reset", 32'(bus.CPU_HOLD), 32'd1);
    check("t6_err_reset",  32'(bus.ERR),      32'd0);
    check("t6_ready_reset", 32'(bus.LD_READY), 32'd0);
    release_and_wait(n, hold_bad);
    check("t6_reclear_latency", 32'(n), 32'd256);
    check("t6_hold_during_reclear", 32'(hold_bad), 32'd0);
    beat(8'h41, 16'h1111, 1'b1);
    check("t6_run_again", 32'(bus.CPU_HOLD), 32'd0);
    set_mar(16'h0040);
    read_exp("t6_prior_beat_zeroed", 16'h0000);
    set_mar(16'h0030);
    read_exp("t6_old_run_write_zeroed", 16'h0000);
    set_mar(16'h0041);
    read_exp("t6_new_beat", 16'h1111);

    // A write with MAR_LOAD in the same cycle writes at the old MAR, loads
    // BUS_IN into MAR, and flags an error.
    set_mar(16'h0050);
    bus.RAM_EN = 1'b1; bus.RAM_RW = 1'b0; bus.MAR_LOAD = 1'b1; bus.BUS_IN = 16'h0060;
    tick();
    bus.RAM_EN = 1'b0; bus.RAM_RW = 1'b1; bus.MAR_LOAD = 1'b0;
    check("wrld_mar", 32'(bus.MAR_Q), 32'h60);
    check("wrld_err", 32'(bus.ERR), 32'd1);
    set_mar(16'h0050);
    read_exp("wrld_old_mar_written", 16'h0060);

    repeat (2) tick();
    check("reads_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
